truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential harness that drives every input combination into a combinational function under test and reads back its single-bit output into a packed truth-table word. It sits on the consumer side of a function block. It sweeps `data` from 0 to 2^WIDTH−1, waits a programmable settle time and samples `f`. It then reports the completed minterm mask and, optionally, a comparison against an expected mask. The block turns exhaustive checking of small combinational cells into a one-shot, start/done transaction usable in self-checking benches and on-chip BIST.

## Interface
Parameters:
- WIDTH, 3, number of function inputs; table width is 2^WIDTH
- SETTLE, 1, idle cycles between applying a vector and sampling `f` (0 allowed)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a scan; sampled only in IDLE
- expected  input  2^WIDTH  reference mask, captured on accepted start
- f  input  1  output of function under test
- data  output  [0:WIDTH-1]  vector driven to function; data[0] is MSB
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when table is complete
- table  output  2^WIDTH  table[i] = f sampled while data == i
- mismatch  output  1  table != expected (check build only)
- first_bad  output  WIDTH  lowest index where table and expected differ

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset clears state → IDLE, data=0, busy=0, done=0, table=0, mismatch=0, first_bad=0, idx=0, settle counter=0.
- IDLE: `start` high → capture expected, clear table, idx=0, data=0, busy=1 → SETTLE (or SAMPLE if SETTLE==0).
- SETTLE: count SETTLE cycles with data held; on terminal count → SAMPLE.
- SAMPLE: table[idx] ← f. If idx == 2^WIDTH−1 → DONE; else idx+1, data ← idx+1, reload counter → SETTLE/SAMPLE.
- DONE: done=1 for exactly one cycle, busy=0, evaluate mismatch/first_bad → IDLE.
- data always equals idx while busy; it returns to 0 in IDLE.
- `start` while busy or in DONE is ignored; no queuing.
- table, mismatch and first_bad hold until the next accepted start, which clears them.
- Reset mid-scan aborts immediately and discards partial results; no done pulse.
- idx counter is WIDTH+1 bits internally so the terminal compare does not wrap.

## Timing
- Accepted start at edge E0 → busy=1 and data=0 visible after E0.
- Vector k sampled at edge E0 + (k+1)·(SETTLE+1).
- done high in the cycle after edge E0 + 2^WIDTH·(SETTLE+1). Default: 16 cycles start→done.
- busy falls in the same cycle done rises.
- New start accepted at the earliest one cycle after done (back-to-back scans every 2^WIDTH·(SETTLE+1)+2 cycles).
- `f` must be stable within SETTLE+1 cycles of data changing; the block does not detect violations.

## Configuration
- TRUTH_TABLE_CHECK_EN defined: the expected register and comparator are built. At DONE, mismatch = (table != expected) and first_bad = lowest differing bit index, else 0.
- Undefined: the expected port is present but ignored. mismatch and first_bad are tied to 0 and no compare logic is synthesized. The table, busy and done behaviour is identical.

## Test plan
- Default params, bench model f = ~((data[0]^data[1]) | data[2]), start pulse → data steps 0..7, each held 2 cycles; done at cycle 16; table = 8'h41; busy low with done.
- Same model, expected = 8'h41 (check build) → mismatch=0, first_bad=0. With expected = 8'h45 → mismatch=1, first_bad=2.
- SETTLE=0, f = data[0] → new vector every cycle, done after 8 cycles, table = 8'hF0.
- rst asserted when data==5 → next cycle data=0, busy=0, table=0, no done pulse; a following start yields the full correct table.
- start held high continuously through scan → only one scan runs until DONE, then a second scan starts the cycle after done; table is cleared at the second start.
- Check build off, expected = 8'h00 with table 8'h41 → mismatch stays 0.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Handshake and result bundle between the truth-table scanner and its consumer.
// master = scanner side, slave = consumer / function-under-test side.
interface truth_table_scanner_if #(
    parameter int WIDTH = 3
);
    logic                  start;
    logic [(1<<WIDTH)-1:0] expected;
    logic                  f;
    logic [0:WIDTH-1]      data;
    logic                  busy;
    logic                  done;
    logic [(1<<WIDTH)-1:0] truth_table;
    logic                  mismatch;
    logic [WIDTH-1:0]      first_bad;

    modport master (
        input  start, expected, f,
        output data, busy, done, truth_table, mismatch, first_bad
    );
    modport slave (
        output start, expected, f,
        input  data, busy, done, truth_table, mismatch, first_bad
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector into a combinational cell and packs its output into a truth table.
// Define TRUTH_TABLE_CHECK_EN to build the expected-mask register and comparator.
module truth_table_scanner #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.master bus
);
    localparam int N  = 1 << WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH:0]  IDX_LAST = (WIDTH+1)'(N - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    localparam state_t FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t           state;
    logic [WIDTH:0]   idx;
    logic [WIDTH:0]   idx_nx;
    logic [CW-1:0]    cnt;
    logic [0:WIDTH-1] data_q;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     tbl_q;
    logic [N-1:0]     tbl_final;
    logic             last;

    assign idx_nx = idx + 1'b1;
    assign last   = (idx == IDX_LAST);

    // Table including the bit being sampled this cycle, so the compare can land with done.
    always_comb begin
        tbl_final = tbl_q;
        tbl_final[idx[WIDTH-1:0]] = bus.f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tbl_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    data_q <= '0;
                    if (bus.start) begin
                        tbl_q  <= '0;
                        idx    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= FIRST;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    tbl_q <= tbl_final;
                    if (last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        data_q <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx    <= idx_nx;
                        data_q <= idx_nx[WIDTH-1:0];
                        cnt    <= '0;
                        state  <= FIRST;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data        = data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = tbl_q;

`ifdef TRUTH_TABLE_CHECK_EN
    logic [N-1:0]     exp_q;
    logic [N-1:0]     diff;
    logic [WIDTH-1:0] fb_next;
    logic             mism_q;
    logic [WIDTH-1:0] fb_q;

    // Scan from the top down so the lowest differing index wins.
    always_comb begin
        diff    = tbl_final ^ exp_q;
        fb_next = '0;
        for (int i = N - 1; i >= 0; i--)
            if (diff[i]) fb_next = WIDTH'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            mism_q <= 1'b0;
            fb_q   <= '0;
        end else if (state == S_IDLE && bus.start) begin
            exp_q  <= bus.expected;
            mism_q <= 1'b0;
            fb_q   <= '0;
        end else if (state == S_SAMPLE && last) begin
            mism_q <= |diff;
            fb_q   <= fb_next;
        end
    end

    assign bus.mismatch  = mism_q;
    assign bus.first_bad = fb_q;
`else
    assign bus.mismatch  = 1'b0;
    assign bus.first_bad = '0;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: fixed and random functions scanned and compared to a table model.
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    truth_table_scanner_if #(.WIDTH(3)) bus0 ();
    truth_table_scanner_if #(.WIDTH(3)) bus1 ();

    truth_table_scanner #(.WIDTH(3), .SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    truth_table_scanner #(.WIDTH(3), .SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;

    logic       mode = 1'b0;
    logic [7:0] lut  = 8'h00;
    logic [2:0] dv0;
    assign dv0 = bus0.data;
    always_comb begin
        if (mode) bus0.f = lut[dv0];
        else      bus0.f = ~((bus0.data[0] ^ bus0.data[1]) | bus0.data[2]);
    end
    assign bus1.f = bus1.data[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Expected table of a function given as an index->output map.
    function automatic logic [7:0] model_table(input logic [7:0] fn);
        logic [7:0] t = '0;
        for (int i = 0; i < 8; i++) t[i] = fn[i];
        return t;
    endfunction

    function automatic void model_check(input logic [7:0] t, input logic [7:0] e,
                                        output logic m, output logic [2:0] fb);
        m  = 1'b0;
        fb = 3'd0;
`ifdef TRUTH_TABLE_CHECK_EN
        m = (t != e);
        for (int i = 7; i >= 0; i--) if (t[i] != e[i]) fb = 3'(i);
`endif
    endfunction

    task automatic scan0(input string tag, input logic [7:0] want_tbl, input logic [7:0] exp_mask);
        int j = 0;
        bit seen = 0;
        logic m;
        logic [2:0] fb;
        bus0.expected = exp_mask;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        while (j < 100 && !seen) begin
            if (bus0.done) seen = 1;
            else begin
                chk({tag, "_data"}, 32'(bus0.data), 32'(j / 2));
                chk({tag, "_busy"}, 32'(bus0.busy), 1);
                @(negedge clk);
                j++;
            end
        end
        model_check(want_tbl, exp_mask, m, fb);
        chk({tag, "_latency"}, 32'(j), 16);
        chk({tag, "_busy_at_done"}, 32'(bus0.busy), 0);
        chk({tag, "_table"}, 32'(bus0.truth_table), 32'(want_tbl));
        chk({tag, "_mismatch"}, 32'(bus0.mismatch), 32'(m));
        chk({tag, "_first_bad"}, 32'(bus0.first_bad), 32'(fb));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus0.done), 0);
        chk({tag, "_table_hold"}, 32'(bus0.truth_table), 32'(want_tbl));
    endtask

    initial begin
        int j;
        bit seen;
        logic [7:0] e;
        bus0.start = 1'b0; bus0.expected = '0;
        bus1.start = 1'b0; bus1.expected = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus0.data), 0);
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_done", 32'(bus0.done), 0);
        chk("rst_table", 32'(bus0.truth_table), 0);
        chk("rst_mismatch", 32'(bus0.mismatch), 0);
        chk("rst_first_bad", 32'(bus0.first_bad), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reference function f = ~((d0^d1)|d2) has table 8'h41.
        scan0("fixed_ok", 8'h41, 8'h41);
        scan0("fixed_bad", 8'h41, 8'h45);
        scan0("fixed_zero", 8'h41, 8'h00);

        // SETTLE = 0 instance: one vector per cycle.
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        j = 0; seen = 0;
        while (j < 100 && !seen) begin
            if (bus1.done) seen = 1;
            else begin
                chk("s0_data", 32'(bus1.data), 32'(j));
                @(negedge clk);
                j++;
            end
        end
        chk("s0_latency", 32'(j), 8);
        chk("s0_table", 32'(bus1.truth_table), 32'h0F0);
        @(negedge clk);

        // Reset in the middle of a scan.
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        j = 0;
        while (j < 100 && bus0.data != 3'd5) begin @(negedge clk); j++; end
        chk("abort_reach5", 32'(bus0.data), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_data", 32'(bus0.data), 0);
        chk("abort_busy", 32'(bus0.busy), 0);
        chk("abort_table", 32'(bus0.truth_table), 0);
        seen = 0;
        repeat (20) begin if (bus0.done) seen = 1; @(negedge clk); end
        chk("abort_no_done", 32'(seen), 0);
        scan0("after_abort", 8'h41, 8'h41);

        // start held high: one scan at a time, restart the cycle after done.
        bus0.start = 1'b1;
        j = 0;
        while (j < 100 && !bus0.done) begin @(negedge clk); j++; end
        chk("held_latency", 32'(j), 17);
        chk("held_table", 32'(bus0.truth_table), 32'h41);
        @(negedge clk);
        chk("held_idle_gap", 32'(bus0.busy), 0);
        @(negedge clk);
        bus0.start = 1'b0;
        chk("held_restart_busy", 32'(bus0.busy), 1);
        chk("held_restart_clear", 32'(bus0.truth_table), 0);
        j = 0;
        while (j < 100 && !bus0.done) begin @(negedge clk); j++; end
        chk("held_second_table", 32'(bus0.truth_table), 32'h41);
        @(negedge clk);

        // Random functions and expected masks.
        mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            lut = 8'($urandom);
            e = (r % 3 == 0) ? lut : 8'($urandom);
            scan0("rand", model_table(lut), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
